// File: rtl/bitcount_arbiter.sv
// rtl/bitcount_arbiter.sv - round-robin sharing of one bit-counter between N requesters
// Latches the winner's operand, sequences load/start/done and returns the count with a watchdog.
module bitcount_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int CW      = $clog2(W + 1),
  parameter int TIMEOUT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data_in,
  output logic [N-1:0]         gnt,
  output logic [CW-1:0]        result,
  output logic [$clog2(N)-1:0] result_id,
  output logic                 result_valid,
  output logic                 error,
  output logic                 busy,
  output logic                 bc_s,
  output logic [W-1:0]         bc_data,
  input  logic                 bc_done,
  input  logic [CW-1:0]        bc_result
);

  localparam int IW  = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]     state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  id_reg;
  logic [W-1:0]   op_reg;
  logic [CW-1:0]  res_reg;
  logic           err;
  logic [WDW-1:0] wdog;

  logic [W-1:0]   ops [N];
  logic           win_found;
  logic [IW-1:0]  win_id;
  logic [IW-1:0]  cand;

  for (genvar g = 0; g < N; g++) begin : g_ops
    assign ops[g] = data_in[g*W +: W];
  end

  // First asserted request at or above ptr, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= '0;
      id_reg  <= '0;
      op_reg  <= '0;
      res_reg <= '0;
      err     <= 1'b0;
      wdog    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            id_reg <= win_id;
            op_reg <= ops[win_id];
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          wdog  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          // A done seen on the expiry cycle still counts as a good result.
          if (bc_done) begin
            res_reg <= bc_result;
            err     <= 1'b0;
            state   <= S_DONE;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            res_reg <= '0;
            err     <= 1'b1;
            state   <= S_DONE;
          end else begin
            wdog <= wdog + WDW'(1);
          end
        end
        S_DONE: begin
          ptr   <= (id_reg == IW'(N - 1)) ? '0 : id_reg + IW'(1);
          state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!bc_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    gnt[id_reg] = (state == S_DONE);
  end

  assign result_valid = (state == S_DONE);
  assign error        = (state == S_DONE) && err;
  assign result       = res_reg;
  assign result_id    = id_reg;
  assign busy         = (state != S_IDLE);
  assign bc_s         = (state == S_RUN);
  assign bc_data      = op_reg;

endmodule

// File: tb/tb_bitcount_arbiter.sv
// tb/tb_bitcount_arbiter.sv - scoreboard bench for bitcount_arbiter
// Includes a behavioural bit-counter with programmable latency or a hang mode.
module tb_bitcount_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int CW = 4;
  localparam int TIMEOUT = 16;
  localparam int IW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*W-1:0]    data_in;
  logic [N-1:0]      gnt;
  logic [CW-1:0]     result;
  logic [IW-1:0]     result_id;
  logic              result_valid;
  logic              error;
  logic              busy;
  logic              bc_s;
  logic [W-1:0]      bc_data;
  logic              bc_done;
  logic [CW-1:0]     bc_result;

  bitcount_arbiter #(.N(N), .W(W), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .req(req), .data_in(data_in), .gnt(gnt),
    .result(result), .result_id(result_id), .result_valid(result_valid),
    .error(error), .busy(busy), .bc_s(bc_s), .bc_data(bc_data),
    .bc_done(bc_done), .bc_result(bc_result)
  );

  always #5 clock = ~clock;

  logic [W-1:0] ops [N];
  always_comb begin
    data_in = '0;
    for (int i = 0; i < N; i++) data_in[i*W +: W] = ops[i];
  end

  int errors = 0;
  int checks = 0;
  int mptr = 0;
  int lat = 0;
  bit hang = 1'b0;
  int exp_id[$];
  int exp_res[$];
  int exp_err[$];
  int exp_run[$];
  int run_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  // Bit counter model: loads A while start is low, reports popcount lat+1 cycles into start.
  logic [W-1:0] bcm_a;
  int bcm_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bc_done <= 1'b0;
      bc_result <= '0;
      bcm_a <= '0;
      bcm_cnt <= 0;
    end else if (!bc_s) begin
      bc_done <= 1'b0;
      bcm_a <= bc_data;
      bcm_cnt <= lat;
    end else if (!hang && !bc_done) begin
      if (bcm_cnt == 0) begin
        bc_done <= 1'b1;
        bc_result <= CW'($countones(bcm_a));
      end else begin
        bcm_cnt <= bcm_cnt - 1;
      end
    end
  end

  // Monitor: pops one expectation per result_valid pulse.
  always @(negedge clock) begin
    if (result_valid) begin
      if (exp_id.size() == 0) begin
        chk("unexpected_valid", 32'(result_valid), 32'd0);
      end else begin
        int e_id, e_res, e_err, e_run;
        e_id = exp_id.pop_front();
        e_res = exp_res.pop_front();
        e_err = exp_err.pop_front();
        e_run = exp_run.pop_front();
        chk("result", 32'(result), 32'(e_res));
        chk("result_id", 32'(result_id), 32'(e_id));
        chk("error", 32'(error), 32'(e_err));
        chk("gnt_onehot", 32'(gnt), 32'(1 << e_id));
        chk("run_cycles", 32'(run_len), 32'(e_run));
      end
    end else if (gnt != '0 || error) begin
      chk("gnt_error_idle", {gnt, 3'b0, error}, 32'd0);
    end
    run_len = bc_s ? run_len + 1 : 0;
  end

  function automatic int predict(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic serve(input logic [N-1:0] mask, input int nops, input bit keep);
    int w;
    int served;
    bit ok;
    bit e;
    served = 0;
    req = mask;
    while (req != '0 && served < nops) begin
      w = predict(req);
      e = hang || (lat > TIMEOUT - 2);
      exp_id.push_back(w);
      exp_res.push_back(e ? 0 : $countones(ops[w]));
      exp_err.push_back(int'(e));
      exp_run.push_back(e ? TIMEOUT : lat + 2);
      mptr = (w + 1) % N;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clock);
        if (gnt[w]) begin
          ok = 1'b1;
          break;
        end
      end
      chk("gnt_wait", 32'(ok), 32'd1);
      if (!ok) served = nops;
      if (!keep) req[w] = 1'b0;
      served++;
    end
    req = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mptr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    reset = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) ops[i] = '0;
    repeat (2) @(negedge clock);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_id", 32'(result_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bc_s", 32'(bc_s), 32'd0);
    chk("rst_bc_data", 32'(bc_data), 32'd0);
    reset = 1'b0;

    // Single request with the load cycle observed.
    ops[0] = 8'h55;
    lat = 3;
    fork
      serve(4'b0001, 1, 1'b0);
      begin
        @(negedge clock);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_bc_s", 32'(bc_s), 32'd0);
        chk("load_bc_data", 32'(bc_data), 32'h55);
        @(negedge clock);
        chk("run_bc_s", 32'(bc_s), 32'd1);
      end
    join

    // All four held: order 0,1,2,3,0.
    do_reset();
    ops[0] = 8'h01; ops[1] = 8'h03; ops[2] = 8'h07; ops[3] = 8'hFF;
    lat = 1;
    serve(4'b1111, 5, 1'b1);

    // ptr=2 then 1001: requester 3 first.
    serve(4'b0010, 1, 1'b0);
    serve(4'b1001, 2, 1'b0);

    // Extremes of operand value.
    ops[2] = 8'h00; ops[3] = 8'hFF;
    lat = W;
    serve(4'b0100, 1, 1'b0);
    serve(4'b1000, 1, 1'b0);

    // Done on the last allowed cycle, then one cycle too late.
    ops[0] = 8'hA7;
    lat = TIMEOUT - 2;
    serve(4'b0001, 1, 1'b0);
    lat = TIMEOUT - 1;
    serve(4'b0001, 1, 1'b0);

    // Hung bit counter, then recovery.
    lat = 2;
    hang = 1'b1;
    serve(4'b0010, 1, 1'b0);
    hang = 1'b0;
    serve(4'b0010, 1, 1'b0);

    // Reset in the middle of RUN.
    do_reset();
    ops[1] = 8'h3C; ops[2] = 8'h0F;
    hang = 1'b1;
    req = 4'b0110;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      if (bc_s) begin
        ok = 1'b1;
        break;
      end
    end
    chk("run_reached", 32'(ok), 32'd1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_bc_s", 32'(bc_s), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    req = '0;
    hang = 1'b0;
    mptr = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    serve(4'b0110, 2, 1'b0);

    // Randomised traffic.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0: ops[i] = 8'h00;
          1: ops[i] = 8'hFF;
          default: ops[i] = W'($urandom);
        endcase
      end
      lat = $urandom_range(0, W);
      serve(N'($urandom_range(1, (1 << N) - 1)), N, 1'b0);
    end

    repeat (20) @(negedge clock);
    chk("queue_drained", 32'(exp_id.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
